x3q_fetch_unit: RTL and testbench

//   Parametrised instruction prefetch unit for the next-generation x3q core. It decouples instruction

---
 rtl/x3q_fetch_unit.sv | 119 +++++++++++
 tb/tb_x3q_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/x3q_fetch_unit.sv
// Instruction prefetch: one outstanding sequential read at a time into a DEPTH-entry show-ahead queue.
// Latency: memory_ready at edge N -> instr_valid after edge N; issue stalls while the queue is full or hold=1.
module x3q_fetch_unit #(
    parameter int                 DATA_W     = 16,
    parameter int                 ADDR_W     = 16,
    parameter int                 DEPTH      = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] memory_in,
    input  logic              memory_ready,
    input  logic              hold,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              instr_take,
    output logic              request,
    output logic [ADDR_W-1:0] request_address,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_ptr;
    logic              discard;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic issue, push, pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Redirect outranks everything: it blocks issue and pop, and drops a coincident return.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        pop       = instr_take && (count != '0) && !redirect;
        case (state)
            S_IDLE: begin
                if (!redirect && !hold && (count < DEPTH_C)) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memory_ready) begin
                    push      = !discard && !redirect;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            request         <= 1'b0;
            request_address <= RESET_ADDR;
            fetch_ptr       <= RESET_ADDR;
            discard         <= 1'b0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
        end else begin
            request <= issue;
            if (issue) request_address <= fetch_ptr;

            if (redirect)   fetch_ptr <= redirect_addr;
            else if (issue) fetch_ptr <= fetch_ptr + ADDR_W'(1);

            // A redirect during an outstanding read marks its eventual return as stale.
            if (state == S_WAIT) begin
                if (memory_ready)  discard <= 1'b0;
                else if (redirect) discard <= 1'b1;
            end

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= request_address;
            q_data[wr_ptr] <= memory_in;
        end
    end

    assign instr_valid = (count != '0);
    assign instr_addr  = instr_valid ? q_addr[rd_ptr] : '0;
    assign instr_data  = instr_valid ? q_data[rd_ptr] : '0;
    assign idle        = (state == S_IDLE);

endmodule

// File: tb/tb_x3q_fetch_unit.sv
// Randomized bench for x3q_fetch_unit: memory responder, stimulus, and a queue-based scoreboard monitor.
module tb_x3q_fetch_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] memory_in;
    logic        memory_ready;
    logic        hold, redirect, instr_take;
    logic [15:0] redirect_addr;
    logic        request, instr_valid, idle;
    logic [15:0] request_address, instr_data, instr_addr;

    x3q_fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(D), .RESET_ADDR(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .memory_in(memory_in), .memory_ready(memory_ready),
        .hold(hold), .redirect(redirect), .redirect_addr(redirect_addr), .instr_take(instr_take),
        .request(request), .request_address(request_address), .instr_valid(instr_valid),
        .instr_data(instr_data), .instr_addr(instr_addr), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd40503;
        return t ^ 16'h5A5A;
    endfunction

    // Memory: answers each request after 1..3 cycles (7 when slow) with memf(address).
    bit slow = 1'b0;
    initial begin
        logic [15:0] a;
        int lat;
        memory_ready = 1'b0;
        memory_in    = 16'h0;
        forever begin
            @(negedge clk);
            if (reset_n && request) begin
                a   = request_address;
                lat = slow ? 6 : $urandom_range(0, 2);
                repeat (lat) @(negedge clk);
                memory_ready = 1'b1;
                memory_in    = memf(a);
                @(negedge clk);
                memory_ready = 1'b0;
                memory_in    = 16'($urandom);
            end
        end
    end

    // Inputs as seen by the DUT at each rising edge.
    logic        in_hold, in_redirect, in_take, in_ready;
    logic [15:0] in_raddr;
    always @(posedge clk) begin
        in_hold     = hold;
        in_redirect = redirect;
        in_take     = instr_take;
        in_ready    = memory_ready;
        in_raddr    = redirect_addr;
    end

    // Reference model: queue of expected {addr,data}, next fetch address, one tagged outstanding read.
    logic [15:0] qa[$];
    logic [15:0] qd[$];
    bit          outst = 1'b0;
    logic [15:0] out_addr;
    int          out_gen, gen = 0;
    logic [15:0] mptr = 16'h0;

    always @(negedge clk) begin
        int sz_pre;
        bit exp_issue;
        if (!reset_n) begin
            qa.delete(); qd.delete();
            outst = 1'b0;
            gen++;
            mptr = 16'h0;
            chk("rst_request", 32'(request), 32'd0);
            chk("rst_req_addr", 32'(request_address), 32'h0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_data", 32'(instr_data), 32'h0);
            chk("rst_addr", 32'(instr_addr), 32'h0);
            chk("rst_idle", 32'(idle), 32'd1);
        end else begin
            sz_pre    = qa.size();
            exp_issue = !outst && !in_hold && !in_redirect && (sz_pre < D);
            if (in_redirect) begin
                qa.delete(); qd.delete();
                gen++;
                mptr = in_raddr;
                if (outst && in_ready) outst = 1'b0;
            end else begin
                if (in_take && qa.size() > 0) begin
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                if (outst && in_ready) begin
                    if (out_gen == gen) begin
                        qa.push_back(out_addr);
                        qd.push_back(memf(out_addr));
                    end
                    outst = 1'b0;
                end
            end
            chk("request", 32'(request), 32'(exp_issue));
            if (request) begin
                chk("req_addr", 32'(request_address), 32'(mptr));
                outst    = 1'b1;
                out_addr = request_address;
                out_gen  = gen;
                mptr     = mptr + 16'd1;
            end
            chk("valid", 32'(instr_valid), 32'(qa.size() != 0));
            if (qa.size() > 0) begin
                chk("head_addr", 32'(instr_addr), 32'(qa[0]));
                chk("head_data", 32'(instr_data), 32'(qd[0]));
            end
            chk("idle", 32'(idle), 32'(!outst));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input string nm);
        int i;
        for (i = 0; i < 40 && idle; i++) tick();
        chk(nm, 32'(idle), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; hold = 1'b0; redirect = 1'b0; redirect_addr = 16'h0; instr_take = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();                      // fill to DEPTH with no takes
        instr_take = 1'b1; tick(); instr_take = 1'b0;
        repeat (10) tick();

        instr_take = 1'b1;                       // redirect while a read is outstanding
        wait_busy("busy_before_redirect");
        instr_take = 1'b0;
        redirect = 1'b1; redirect_addr = 16'h0040; tick(); redirect = 1'b0;
        repeat (15) tick();

        instr_take = 1'b1;                       // address wrap
        redirect = 1'b1; redirect_addr = 16'hFFFE; tick(); redirect = 1'b0;
        repeat (30) tick();

        for (int i = 0; i < 1500; i++) begin
            hold          = ($urandom_range(0, 9) < 2);
            instr_take    = ($urandom_range(0, 9) < 4);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_addr = ($urandom_range(0, 1) == 1) ? 16'hFFFD : 16'($urandom);
            tick();
        end
        hold = 1'b0; redirect = 1'b0; instr_take = 1'b1;

        slow = 1'b1;                             // reset in the middle of a slow read
        wait_busy("busy_before_reset");
        instr_take = 1'b0;
        hold = 1'b1;
        reset_n = 1'b0; tick(); tick();
        reset_n = 1'b1;
        repeat (12) tick();                      // late memory_ready lands while idle
        slow = 1'b0;
        hold = 1'b0; instr_take = 1'b1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
